// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared widths, state encoding and counter-width helper for the line-FIFO replay sequencer.
package fifo_ctrl_pkg;
  localparam int FIFO_SIZE_DEF = 4608;
  localparam int PAD_W = 2;
  localparam int REP_W = 8;
  function automatic int cnt_width(input int size);
    return $clog2(size) + 1;
  endfunction
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_PAD_PRE,
    S_READ,
    S_PAD_POST,
    S_REWIND,
    S_DONE
  } state_t;
endpackage

// File: rtl/fifo_replay_ctrl.sv
// fifo_replay_ctrl: loads one row into a line FIFO, then replays it cfg_repeat times framed by cfg_pad zero words.
module fifo_replay_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = FIFO_SIZE_DEF,
  parameter int CNT_W      = cnt_width(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic [REP_W-1:0]      cfg_repeat,
  input  logic [PAD_W-1:0]      cfg_pad,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fifo_rd_clr,
  output logic                  fifo_wr_clr,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_inc,
  output logic                  fifo_wr_en,
  output logic                  fifo_wr_inc,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_cnt_q, rep_cnt_d;
  logic [PAD_W-1:0] pad_q, pad_d, pad_cnt_q, pad_cnt_d;
  logic emit_q, emit_d, err_q, err_d;
  logic cfg_ok, len_last, pad_last, rep_last, has_pad;

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= CNT_W'(FIFO_SIZE)) && (cfg_repeat != '0);
  assign len_last = (cnt_q + CNT_W'(1)) == len_q;
  assign pad_last = (pad_cnt_q + PAD_W'(1)) == pad_q;
  assign rep_last = (rep_cnt_q + REP_W'(1)) == rep_q;
  assign has_pad  = pad_q != '0;

  // The last replay skips REWIND so done lands on the final frame word.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rep_d     = rep_q;
    pad_d     = pad_q;
    cnt_d     = cnt_q;
    pad_cnt_d = pad_cnt_q;
    rep_cnt_d = rep_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (cfg_ok) begin
          len_d     = cfg_len;
          rep_d     = cfg_repeat;
          pad_d     = cfg_pad;
          cnt_d     = '0;
          pad_cnt_d = '0;
          rep_cnt_d = '0;
          state_d   = S_CLEAR;
        end else err_d = 1'b1;
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: if (in_valid) begin
        cnt_d = len_last ? '0 : cnt_q + CNT_W'(1);
        if (len_last) state_d = has_pad ? S_PAD_PRE : S_READ;
      end
      S_PAD_PRE: begin
        pad_cnt_d = pad_last ? '0 : pad_cnt_q + PAD_W'(1);
        if (pad_last) state_d = S_READ;
      end
      S_READ: begin
        cnt_d = len_last ? '0 : cnt_q + CNT_W'(1);
        if (len_last) state_d = has_pad ? S_PAD_POST : rep_last ? S_DONE : S_REWIND;
      end
      S_PAD_POST: begin
        pad_cnt_d = pad_last ? '0 : pad_cnt_q + PAD_W'(1);
        if (pad_last) state_d = rep_last ? S_DONE : S_REWIND;
      end
      S_REWIND: begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
        state_d   = has_pad ? S_PAD_PRE : S_READ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign emit_d = (state_q == S_PAD_PRE) || (state_q == S_READ) || (state_q == S_PAD_POST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rep_q     <= '0;
      pad_q     <= '0;
      cnt_q     <= '0;
      pad_cnt_q <= '0;
      rep_cnt_q <= '0;
      emit_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      pad_q     <= pad_d;
      cnt_q     <= cnt_d;
      pad_cnt_q <= pad_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      emit_q    <= emit_d;
      err_q     <= err_d;
    end
  end

  assign in_ready     = state_q == S_LOAD;
  assign fifo_wr_en   = in_ready && in_valid;
  assign fifo_wr_inc  = fifo_wr_en;
  assign fifo_wr_clr  = state_q == S_CLEAR;
  assign fifo_rd_clr  = (state_q == S_CLEAR) || (state_q == S_REWIND);
  assign fifo_rd_en   = state_q == S_READ;
  assign fifo_rd_inc  = fifo_rd_en;
  assign fifo_data_in = in_data;
  assign out_valid    = emit_q;
  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_DONE;
  assign cfg_err      = err_q;
endmodule

// File: tb/tb_fifo_replay_ctrl.sv
// tb_fifo_replay_ctrl: directed bench with a behavioural line FIFO capturing the framed replay stream.
module tb_fifo_replay_ctrl;
  localparam int DW = 16;
  localparam int FS = 4608;
  localparam int CW = $clog2(FS) + 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic [7:0] cfg_repeat = '0;
  logic [1:0] cfg_pad = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, fifo_rd_clr, fifo_wr_clr, fifo_rd_en, fifo_rd_inc, fifo_wr_en, fifo_wr_inc;
  logic [DW-1:0] fifo_data_in;
  logic out_valid, busy, done, cfg_err;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fifo_replay_ctrl #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_repeat(cfg_repeat),
    .cfg_pad(cfg_pad), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_rd_clr(fifo_rd_clr), .fifo_wr_clr(fifo_wr_clr), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_inc(fifo_rd_inc), .fifo_wr_en(fifo_wr_en), .fifo_wr_inc(fifo_wr_inc),
    .fifo_data_in(fifo_data_in), .out_valid(out_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  logic [DW-1:0] mem [FS];
  int wp = 0, rp = 0;
  logic [DW-1:0] fifo_q = '0;
  always @(posedge clk) begin
    if (fifo_wr_clr) wp <= 0;
    else if (fifo_wr_en) begin
      mem[wp] <= fifo_data_in;
      if (fifo_wr_inc) wp <= (wp == FS - 1) ? 0 : wp + 1;
    end
    if (fifo_rd_clr) rp <= 0;
    else if (fifo_rd_inc) rp <= (rp == FS - 1) ? 0 : rp + 1;
    fifo_q <= fifo_rd_en ? mem[rp] : '0;
  end

  // Frame words are pushed as values; a -1 marks an idle cycle between replays.
  int got[$];
  int wr_cnt = 0, strobe_cnt = 0, done_cnt = 0;
  logic done_ov = 1'b0, prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid) got.push_back(int'(fifo_q));
    else if (prev_ov && busy) got.push_back(-1);
    prev_ov <= out_valid;
    if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
    if (fifo_rd_en | fifo_wr_en | fifo_rd_clr | fifo_wr_clr | fifo_rd_inc | fifo_wr_inc)
      strobe_cnt <= strobe_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_ov  <= out_valid;
    end
  end

  int words[$];
  int exp[$];

  function automatic logic [10:0] outs();
    return {in_ready, fifo_rd_clr, fifo_wr_clr, fifo_rd_en, fifo_rd_inc, fifo_wr_en,
            fifo_wr_inc, out_valid, busy, done, cfg_err};
  endfunction

  task automatic build_exp(input int rep, input int pad);
    exp.delete();
    for (int r = 0; r < rep; r++) begin
      for (int p = 0; p < pad; p++) exp.push_back(0);
      foreach (words[i]) exp.push_back(words[i]);
      for (int p = 0; p < pad; p++) exp.push_back(0);
      if (r < rep - 1) exp.push_back(-1);
    end
  endtask

  function automatic int first_diff(input int base);
    for (int i = 0; i < exp.size(); i++)
      if (base + i >= got.size() || got[base + i] != exp[i]) return i;
    return -1;
  endfunction

  task automatic do_start(input int len, input int rep, input int pad);
    @(negedge clk);
    cfg_len = CW'(len);
    cfg_repeat = 8'(rep);
    cfg_pad = 2'(pad);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gap, input int start_at);
    int n;
    foreach (words[i]) begin
      in_valid = 1'b1;
      in_data = DW'(words[i]);
      if (i == start_at) begin
        start = 1'b1;
        cfg_len = CW'(2);
        cfg_repeat = 8'd1;
        cfg_pad = 2'd0;
      end
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      start = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (outs() !== 11'd0) begin bad++; $display("FAIL reset_outs: got=%b exp=%b", outs(), 11'd0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base, w0, d0, fd;
    bit ok;
    words = {10, 11, 12, 13};
    base = got.size(); w0 = wr_cnt; d0 = done_cnt;
    do_start(4, 2, 1);
    total++;
    if ({fifo_rd_clr, fifo_wr_clr, busy, in_ready} !== 4'b1110) begin
      bad++; $display("FAIL basic_clear: got=%b exp=1110", {fifo_rd_clr, fifo_wr_clr, busy, in_ready});
    end
    feed(1'b0, -1);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: busy=%b exp=0", busy); end
    exp = {0, 10, 11, 12, 13, 0, -1, 0, 10, 11, 12, 13, 0};
    total++;
    if (got.size() - base != exp.size()) begin bad++; $display("FAIL basic_len: got=%0d exp=%0d", got.size() - base, exp.size()); end
    fd = first_diff(base);
    total++;
    if (fd != -1) begin bad++; $display("FAIL basic_data: idx=%0d got=%0d exp=%0d", fd, got[base + fd], exp[fd]); end
    total++;
    if (done_cnt - d0 != 1 || done_ov !== 1'b1) begin bad++; $display("FAIL basic_done: pulses=%0d with_valid=%b exp=1/1", done_cnt - d0, done_ov); end
    total++;
    if (wr_cnt - w0 != 4) begin bad++; $display("FAIL basic_writes: got=%0d exp=4", wr_cnt - w0); end
  endtask

  task automatic test_gaps();
    int base, w0, fd;
    bit ok;
    words = {21, 22, 23};
    base = got.size(); w0 = wr_cnt;
    do_start(3, 1, 0);
    feed(1'b1, -1);
    wait_idle(ok);
    exp = {21, 22, 23};
    total++;
    if (!ok || got.size() - base != 3) begin bad++; $display("FAIL gaps_len: got=%0d exp=3 ok=%b", got.size() - base, ok); end
    fd = first_diff(base);
    total++;
    if (fd != -1) begin bad++; $display("FAIL gaps_data: idx=%0d got=%0d exp=%0d", fd, got[base + fd], exp[fd]); end
    total++;
    if (wr_cnt - w0 != 3) begin bad++; $display("FAIL gaps_writes: got=%0d exp=3", wr_cnt - w0); end
    total++;
    if (done_ov !== 1'b1) begin bad++; $display("FAIL gaps_done_last: got=%b exp=1", done_ov); end
  endtask

  task automatic test_full();
    int base, w0, fd;
    bit ok;
    words.delete();
    for (int i = 0; i < FS; i++) words.push_back((i * 7 + 3) & 16'hFFFF);
    base = got.size(); w0 = wr_cnt;
    do_start(FS, 1, 0);
    feed(1'b0, -1);
    wait_idle(ok);
    build_exp(1, 0);
    total++;
    if (!ok || got.size() - base != FS) begin bad++; $display("FAIL full_len: got=%0d exp=%0d ok=%b", got.size() - base, FS, ok); end
    fd = first_diff(base);
    total++;
    if (fd != -1) begin bad++; $display("FAIL full_data: idx=%0d got=%0d exp=%0d", fd, got[base + fd], exp[fd]); end
    total++;
    if (wr_cnt - w0 != FS) begin bad++; $display("FAIL full_writes: got=%0d exp=%0d", wr_cnt - w0, FS); end
  endtask

  task automatic test_cfg_err();
    int lens[3] = '{0, FS + 1, 4};
    int reps[3] = '{1, 1, 0};
    int s0;
    for (int k = 0; k < 3; k++) begin
      s0 = strobe_cnt;
      do_start(lens[k], reps[k], 1);
      total++;
      if ({cfg_err, busy} !== 2'b10) begin bad++; $display("FAIL err_pulse%0d: err/busy=%b exp=10", k, {cfg_err, busy}); end
      @(negedge clk);
      total++;
      if ({cfg_err, busy} !== 2'b00) begin bad++; $display("FAIL err_clear%0d: err/busy=%b exp=00", k, {cfg_err, busy}); end
      total++;
      if (strobe_cnt != s0) begin bad++; $display("FAIL err_strobes%0d: got=%0d exp=0", k, strobe_cnt - s0); end
    end
  endtask

  task automatic test_reset_mid();
    int base, fd, n;
    bit ok;
    words = {1, 2, 3, 4};
    do_start(4, 3, 1);
    feed(1'b0, -1);
    n = 0;
    while (!fifo_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL mid_reach_read: rd_en=%b exp=1", fifo_rd_en); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 11'd0) begin bad++; $display("FAIL mid_async_outs: got=%b exp=%b", outs(), 11'd0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    words = {40, 41, 42, 43};
    base = got.size();
    do_start(4, 2, 1);
    total++;
    if ({fifo_rd_clr, fifo_wr_clr} !== 2'b11) begin bad++; $display("FAIL mid_clear_first: got=%b exp=11", {fifo_rd_clr, fifo_wr_clr}); end
    feed(1'b0, -1);
    wait_idle(ok);
    build_exp(2, 1);
    total++;
    if (!ok || got.size() - base != exp.size()) begin bad++; $display("FAIL mid_len: got=%0d exp=%0d", got.size() - base, exp.size()); end
    fd = first_diff(base);
    total++;
    if (fd != -1) begin bad++; $display("FAIL mid_data: idx=%0d got=%0d exp=%0d", fd, got[base + fd], exp[fd]); end
  endtask

  task automatic test_start_in_load();
    int base, w0, d0, fd;
    bit ok;
    words = {5, 6, 7, 8};
    base = got.size(); w0 = wr_cnt; d0 = done_cnt;
    do_start(4, 2, 1);
    feed(1'b0, 1);
    wait_idle(ok);
    exp = {0, 5, 6, 7, 8, 0, -1, 0, 5, 6, 7, 8, 0};
    total++;
    if (!ok || got.size() - base != exp.size()) begin bad++; $display("FAIL sil_len: got=%0d exp=%0d", got.size() - base, exp.size()); end
    fd = first_diff(base);
    total++;
    if (fd != -1) begin bad++; $display("FAIL sil_data: idx=%0d got=%0d exp=%0d", fd, got[base + fd], exp[fd]); end
    total++;
    if (wr_cnt - w0 != 4 || done_cnt - d0 != 1) begin bad++; $display("FAIL sil_counts: writes=%0d done=%0d exp=4/1", wr_cnt - w0, done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_cfg_err();
    test_start_in_load();
    test_reset_mid();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
